// File: rtl/serial_subtractor.sv
// serial_subtractor: WIDTH-bit subtractor (diff = a - b) that resolves DIGIT
// bits per clock, least-significant digit first, behind a start/busy/done
// handshake. Results are registered and held until the next operation ends.
// Optional feature macro: SERIAL_SUB_OVERFLOW_EN adds the 'overflow' output
// (signed two's-complement overflow of a - b).
module serial_subtractor #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SERIAL_SUB_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  // Reject configurations where the digits do not tile the word exactly.
  if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
    $error("serial_subtractor: WIDTH must be a positive multiple of DIGIT");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_state_next;

  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_res;
  logic [WIDTH-1:0]   r_diff;
  logic               r_borrow;
  logic               r_bin;
  logic [CW-1:0]      r_cnt;

  logic [DIGIT:0]     w_sub;
  logic [DIGIT-1:0]   w_d;
  logic               w_bout;
  logic               w_last;
  logic [WIDTH-1:0]   w_a_shift;
  logic [WIDTH-1:0]   w_b_shift;
  logic [WIDTH-1:0]   w_res_next;

`ifdef SERIAL_SUB_OVERFLOW_EN
  logic               r_sa;
  logic               r_sb;
  logic               r_ovf;
`endif

  // One digit of the borrow chain: a DIGIT+1 bit difference whose top bit
  // is the borrow out (set whenever the digit underflows).
  assign w_sub  = {1'b0, r_a[DIGIT-1:0]} - {1'b0, r_b[DIGIT-1:0]}
                - {{DIGIT{1'b0}}, r_bin};
  assign w_d    = w_sub[DIGIT-1:0];
  assign w_bout = w_sub[DIGIT];
  assign w_last = (r_cnt == CW'(N - 1));

  // Operand/result shifting; a single-digit word has nothing left to shift.
  if (DIGIT == WIDTH) begin : g_single
    assign w_a_shift  = '0;
    assign w_b_shift  = '0;
    assign w_res_next = w_d;
  end else begin : g_multi
    assign w_a_shift  = {{DIGIT{1'b0}}, r_a[WIDTH-1:DIGIT]};
    assign w_b_shift  = {{DIGIT{1'b0}}, r_b[WIDTH-1:DIGIT]};
    assign w_res_next = {w_d, r_res[WIDTH-1:DIGIT]};
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        busy         = 1'b1;
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Datapath: capture operands on an accepted start, then ripple one digit
  // per clock; the visible result only changes on the final digit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_bin    <= 1'b0;
      r_cnt    <= '0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_ovf    <= 1'b0;
`endif
    end else if (r_state == S_IDLE) begin
      if (start) begin
        r_a   <= a;
        r_b   <= b;
        r_bin <= 1'b0;
        r_cnt <= '0;
`ifdef SERIAL_SUB_OVERFLOW_EN
        r_sa  <= a[WIDTH-1];
        r_sb  <= b[WIDTH-1];
`endif
      end
    end else if (r_state == S_RUN) begin
      r_a   <= w_a_shift;
      r_b   <= w_b_shift;
      r_res <= w_res_next;
      r_bin <= w_bout;
      r_cnt <= r_cnt + CW'(1);
      if (w_last) begin
        r_diff   <= w_res_next;
        r_borrow <= w_bout;
`ifdef SERIAL_SUB_OVERFLOW_EN
        // The last digit carries the result sign bit.
        r_ovf    <= (r_sa != r_sb) && (w_d[DIGIT-1] != r_sa);
`endif
      end
    end
  end

  assign diff   = r_diff;
  assign borrow = r_borrow;
`ifdef SERIAL_SUB_OVERFLOW_EN
  assign overflow = r_ovf;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: randomized and directed bench for serial_subtractor.
// A transaction-level model predicts busy/done/diff/borrow every cycle; a few
// directed operations pin the model with hand-computed results and latencies.
module tb_serial_subtractor;

  localparam int W   = 32;
  localparam int D   = 4;
  localparam int N   = W / D;
  localparam int N8  = W / 8;
  localparam int N32 = W / 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         start8 = 1'b0;
  logic         start32 = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;

  logic         busy, done, borrow;
  logic [W-1:0] diff;
  logic         busy8, done8, borrow8;
  logic [W-1:0] diff8;
  logic         busy32, done32, borrow32;
  logic [W-1:0] diff32;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic         ovf, ovf8, ovf32;
`endif

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;
  int cyc = 0;

  serial_subtractor #(.WIDTH(W), .DIGIT(D)) u_dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .borrow(borrow)
`ifdef SERIAL_SUB_OVERFLOW_EN
    , .overflow(ovf)
`endif
  );

  serial_subtractor #(.WIDTH(W), .DIGIT(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a), .b(b),
    .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8)
`ifdef SERIAL_SUB_OVERFLOW_EN
    , .overflow(ovf8)
`endif
  );

  serial_subtractor #(.WIDTH(W), .DIGIT(32)) u_dut32 (
    .clk(clk), .rst(rst), .start(start32), .a(a), .b(b),
    .busy(busy32), .done(done32), .diff(diff32), .borrow(borrow32)
`ifdef SERIAL_SUB_OVERFLOW_EN
    , .overflow(ovf32)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Signed overflow from plain wide signed arithmetic.
  function automatic logic ovf_of(input logic [W-1:0] x, input logic [W-1:0] y);
    longint sx, sy, sd, hi, lo;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    sd = sx - sy;
    hi = (longint'(1) <<< (W - 1)) - 1;
    lo = -(longint'(1) <<< (W - 1));
    return (sd > hi) || (sd < lo);
  endfunction

  // Transaction model: an accepted operation keeps the unit busy for N+1
  // cycles; its result appears in the last of them and is then held.
  int           m_left = 0;
  logic [W-1:0] m_pd = '0;
  logic         m_pb = 1'b0;
  logic         m_po = 1'b0;
  logic [W-1:0] m_diff = '0;
  logic         m_borrow = 1'b0;
  logic         m_ovf = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left   = 0;
      m_diff   = '0;
      m_borrow = 1'b0;
      m_ovf    = 1'b0;
    end else if (m_left == 0) begin
      if (start) begin
        m_pd   = a - b;
        m_pb   = (a < b);
        m_po   = ovf_of(a, b);
        m_left = N + 1;
      end
    end else begin
      m_left = m_left - 1;
      if (m_left == 1) begin
        m_diff   = m_pd;
        m_borrow = m_pb;
        m_ovf    = m_po;
      end
    end
  end

  // Per-cycle comparison of the main DUT against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      vectors++;
      if (busy !== (m_left > 0) || done !== (m_left == 1) ||
          diff !== m_diff || borrow !== m_borrow
`ifdef SERIAL_SUB_OVERFLOW_EN
          || ovf !== m_ovf
`endif
         ) begin
        miscompares++;
        $display("FAIL cycle t=%0t: busy=%b/%b done=%b/%b diff=%h/%h borrow=%b/%b (got/required)",
                 $time, busy, (m_left > 0), done, (m_left == 1), diff, m_diff, borrow, m_borrow);
      end else if (done === 1'b1) begin
        $display("txn t=%0t diff=%h borrow=%b", $time, diff, borrow);
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic [W-1:0] ed, input logic eb, input logic eo,
                        input string name);
    int lat;
    $display("op %s a=%h b=%h exp_diff=%h exp_borrow=%b exp_ovf=%b", name, ia, ib, ed, eb, eo);
    @(posedge clk); #2;
    a = ia; b = ib; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    a = $urandom; b = $urandom;
    @(negedge clk);
    lat = 1;
    check({name, " busy"}, 64'(busy), 64'(1));
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({name, " latency"}, 64'(lat), 64'(N + 1));
    check({name, " diff"}, 64'(diff), 64'(ed));
    check({name, " borrow"}, 64'(borrow), 64'(eb));
`ifdef SERIAL_SUB_OVERFLOW_EN
    check({name, " overflow"}, 64'(ovf), 64'(eo));
`endif
  endtask

  task automatic run_aux(input int sel);
    int lat;
    logic dn;
    @(posedge clk); #2;
    a = 32'd2; b = 32'd1;
    if (sel == 8) start8 = 1'b1; else start32 = 1'b1;
    @(posedge clk); #2;
    start8 = 1'b0; start32 = 1'b0;
    lat = 0;
    dn  = 1'b0;
    while (dn !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
      dn = (sel == 8) ? done8 : done32;
    end
    $display("op aux DIGIT=%0d latency=%0d", sel, lat);
    check($sformatf("aux%0d latency", sel), 64'(lat), 64'((sel == 8) ? N8 + 1 : N32 + 1));
    check($sformatf("aux%0d diff", sel), 64'((sel == 8) ? diff8 : diff32), 64'(1));
    check($sformatf("aux%0d borrow", sel), 64'((sel == 8) ? borrow8 : borrow32), 64'(0));
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      3: return W'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int ndone;
    int tdone[3];
    logic [W-1:0] d_at;

    // Reset state.
    chk_en = 1'b1;
    @(negedge clk);
    check("reset busy", 64'(busy), 64'(0));
    check("reset done", 64'(done), 64'(0));
    check("reset diff", 64'(diff), 64'(0));
    check("reset borrow", 64'(borrow), 64'(0));
    @(posedge clk); #2;
    rst = 1'b0;

    // Basic timing and hold.
    run_op(32'd2, 32'd1, 32'd1, 1'b0, 1'b0, "basic");
    repeat (5) @(negedge clk);
    check("basic hold diff", 64'(diff), 64'(1));

    // Reset in the middle of RUN.
    @(posedge clk); #2;
    a = 32'd5; b = 32'd3; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    check("midrst busy", 64'(busy), 64'(0));
    check("midrst diff", 64'(diff), 64'(0));
    check("midrst borrow", 64'(borrow), 64'(0));
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    ndone = 0;
    repeat (15) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    check("midrst no done", 64'(ndone), 64'(0));
    run_op(32'd5, 32'd3, 32'd2, 1'b0, 1'b0, "after_rst");

    // Wrap-around and borrow chains.
    run_op(32'd0, 32'd1, 32'hFFFF_FFFF, 1'b1, 1'b0, "wrap0");
    run_op(32'd1, 32'd2, 32'hFFFF_FFFF, 1'b1, 1'b0, "wrap1");
    run_op(32'h0000_FFFF, 32'h0002_CCC1, 32'hFFFE_333E, 1'b1, 1'b0, "chain0");
    run_op(32'h0002_CCC1, 32'h0000_FFFF, 32'h0001_CCC2, 1'b0, 1'b0, "chain1");
    run_op(32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0, 1'b1, "ovf1");
    run_op(32'd3, 32'd1, 32'd2, 1'b0, 1'b0, "ovf0");

    // Start while busy is ignored.
    @(posedge clk); #2;
    a = 32'd7; b = 32'd2; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    @(posedge clk); #2;
    a = 32'd9; b = 32'd9; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    ndone = 0;
    d_at = '0;
    repeat (20) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ndone++;
        d_at = diff;
      end
    end
    check("busy_start done count", 64'(ndone), 64'(1));
    check("busy_start diff", 64'(d_at), 64'(5));

    // Start held high: back-to-back operations.
    @(posedge clk); #2;
    start = 1'b1;
    ndone = 0;
    for (int i = 0; i < 60 && ndone < 3; i++) begin
      @(negedge clk);
      a = $urandom; b = $urandom;
      if (done === 1'b1) begin
        tdone[ndone] = cyc;
        ndone++;
      end
    end
    start = 1'b0;
    check("b2b done count", 64'(ndone), 64'(3));
    check("b2b spacing01", 64'(tdone[1] - tdone[0]), 64'(N + 2));
    check("b2b spacing12", 64'(tdone[2] - tdone[1]), 64'(N + 2));
    repeat (12) @(posedge clk);

    // Other digit widths.
    run_aux(8);
    run_aux(32);

    // Randomized traffic with occasional asynchronous resets.
    repeat (3000) begin
      @(posedge clk); #2;
      rst   = ($urandom_range(0, 299) == 0);
      start = ($urandom_range(0, 2) != 0);
      a     = pick();
      b     = pick();
    end
    @(posedge clk); #2;
    rst = 1'b0;
    start = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
